// File: rtl/adder_pipe.sv
// Pipelined add/sub/saturating adder with valid/ready flow control.
// Arithmetic is done in stage 0; later stages only carry sum, cout and ovf.
module adder_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned W1   = WIDTH + 1;
    localparam int unsigned LAST = STAGES - 1;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_SATU = 2'b10;
    localparam logic [1:0] OP_SATS = 2'b11;

    localparam logic [WIDTH-1:0] MAX_POS = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] load;
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [STAGES-1:0] cout_q;
    logic [STAGES-1:0] ovf_q;

    logic [WIDTH-1:0]  b_eff;
    logic [W1-1:0]     raw;
    logic [WIDTH-1:0]  res_sum;
    logic              res_cout;
    logic              res_ovf;
    logic              s_ovf;

    // A stage may load when empty or when its contents leave this cycle.
    always_comb begin
        load       = '0;
        load[LAST] = !valid_q[LAST] || out_ready;
        for (int i = int'(LAST) - 1; i >= 0; i--) begin
            load[i] = !valid_q[i] || load[i+1];
        end
    end

    // Subtraction as a + ~b + 1 so the carry-out is the inverted borrow.
    always_comb begin
        b_eff    = (op == OP_SUB) ? ~b : b;
        raw      = W1'(a) + W1'(b_eff) + W1'(op == OP_SUB);
        s_ovf    = (a[WIDTH-1] == b_eff[WIDTH-1]) && (raw[WIDTH-1] != a[WIDTH-1]);
        res_sum  = raw[WIDTH-1:0];
        res_cout = raw[WIDTH];
        res_ovf  = s_ovf;
        case (op)
            OP_ADD, OP_SUB: begin
                res_ovf = s_ovf;
            end
            OP_SATU: begin
                res_ovf = raw[WIDTH];
                if (raw[WIDTH]) begin
                    res_sum = '1;
                end
            end
            OP_SATS: begin
                res_ovf = s_ovf;
                if (s_ovf) begin
                    res_sum = a[WIDTH-1] ? MIN_NEG : MAX_POS;
                end
            end
            default: begin
                res_ovf = s_ovf;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
            cout_q  <= '0;
            ovf_q   <= '0;
            for (int i = 0; i < int'(STAGES); i++) begin
                sum_q[i] <= '0;
            end
        end else begin
            if (load[0]) begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    sum_q[0]  <= res_sum;
                    cout_q[0] <= res_cout;
                    ovf_q[0]  <= res_ovf;
                end
            end
            for (int i = 1; i < int'(STAGES); i++) begin
                if (load[i]) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        sum_q[i]  <= sum_q[i-1];
                        cout_q[i] <= cout_q[i-1];
                        ovf_q[i]  <= ovf_q[i-1];
                    end
                end
            end
        end
    end

    assign in_ready  = load[0];
    assign out_valid = valid_q[LAST];
    assign sum       = sum_q[LAST];
    assign cout      = cout_q[LAST];
    assign ovf       = ovf_q[LAST];

endmodule
